// File: rtl/fp_conv_pkg.sv
// Shared definitions for the int<->fp conversion stages: exponent bias,
// field widths and the FSM state encoding.
package fp_conv_pkg;

    // Exponent given to an 8-bit fraction that needed no normalising shift.
    localparam logic [3:0] EXP_BASE = 4'hA;
    localparam int         EXP_W    = 4;
    localparam int         FRAC_W   = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_NORM = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/fp_lzc8.sv
// 8-bit leading-zero counter: count_o = number of zeros above the highest
// set bit, 8 for an all-zero input.
module fp_lzc8 (
    input  logic [7:0] data_i,
    output logic [3:0] count_o
);

    // Scan upward so the highest set bit is the last one to win.
    always_comb begin
        count_o = 4'd8;
        for (int i = 0; i < 8; i++) begin
            if (data_i[i]) begin
                count_o = 4'(7 - i);
            end
        end
    end

endmodule

// File: rtl/int_fp_norm.sv
// Sign-magnitude 8-bit integer to sign/exponent/fraction converter.
// One word in flight at a time: IDLE accepts, NORM normalises, DONE holds
// the result until downstream takes it.
// Optional macro FP_NORM_FAST_EN: normalise in one NORM cycle using a
// leading-zero count instead of shifting one bit per cycle.
//
// Handshakes: a word transfers on a clk edge where in_valid && in_ready;
// a result transfers on a clk edge where out_valid && out_ready. Result
// fields are held stable while out_valid is high and out_ready is low.
module int_fp_norm #(
    parameter logic [3:0] EXP_BASE = fp_conv_pkg::EXP_BASE
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [7:0] in_int,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       sign_o,
    output logic [3:0] exp_o,
    output logic [7:0] frac_o,
    output logic [1:0] dbg_state_o
);
    import fp_conv_pkg::*;

    localparam logic [EXP_W-1:0] EXP_ONE = EXP_W'(1);

    state_t              state_q, state_d;
    logic                sign_q, sign_d;
    logic [EXP_W-1:0]    exp_q, exp_d;
    logic [FRAC_W-1:0]   frac_q, frac_d;

`ifdef FP_NORM_FAST_EN
    logic [3:0] lz_cnt;

    fp_lzc8 u_lzc (
        .data_i  (frac_q),
        .count_o (lz_cnt)
    );
`endif

    // Next-state and datapath update; everything holds unless a case moves it.
    always_comb begin
        state_d = state_q;
        sign_d  = sign_q;
        exp_d   = exp_q;
        frac_d  = frac_q;
        unique case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    sign_d  = in_int[7];
                    frac_d  = {in_int[6:0], 1'b0};
                    exp_d   = EXP_BASE;
                    state_d = ST_NORM;
                end
            end
            ST_NORM: begin
`ifdef FP_NORM_FAST_EN
                state_d = ST_DONE;
                if (frac_q == '0) begin
                    exp_d = '0;
                end else begin
                    frac_d = frac_q << lz_cnt;
                    exp_d  = exp_q - lz_cnt;
                end
`else
                if (frac_q == '0) begin
                    // Zero magnitude reports exponent 0; sign is kept.
                    exp_d   = '0;
                    state_d = ST_DONE;
                end else if (frac_q[FRAC_W-1]) begin
                    state_d = ST_DONE;
                end else begin
                    frac_d = frac_q << 1;
                    exp_d  = exp_q - EXP_ONE;
                end
`endif
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and datapath registers; reset drops any word in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            sign_q  <= 1'b0;
            exp_q   <= '0;
            frac_q  <= '0;
        end else begin
            state_q <= state_d;
            sign_q  <= sign_d;
            exp_q   <= exp_d;
            frac_q  <= frac_d;
        end
    end

    assign in_ready    = (state_q == ST_IDLE);
    assign out_valid   = (state_q == ST_DONE);
    assign sign_o      = sign_q;
    assign exp_o       = exp_q;
    assign frac_o      = frac_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_int_fp_norm.sv
// Bench for int_fp_norm: directed corner words, a backpressure stall,
// a mid-normalisation reset and a shuffled sweep of all 256 inputs with
// random downstream backpressure. Results are checked against a reference
// model and reconverted to an integer to confirm the round trip.
module tb_int_fp_norm;

    localparam logic [3:0] EXP_BASE = 4'hA;
    localparam int         W        = 26;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic [7:0] in_int = 8'h00;
    logic       out_ready = 1'b1;
    logic       in_ready;
    logic       out_valid;
    logic       sign_o;
    logic [3:0] exp_o;
    logic [7:0] frac_o;
    logic [1:0] dbg_state;

    int n_cmp = 0;
    int n_fail = 0;
    int ready_mode = 0;

    // {in_int, exp, frac, latency}
    logic [W-1:0] exp_q[$];

    int          mon_lat = 0;
    int          mon_lat_seen = 0;
    bit          mon_tracking = 1'b0;
    bit          mon_seen = 1'b0;
    bit          mon_have_snap = 1'b0;
    logic [12:0] mon_snap = '0;
    logic [W-1:0] mon_item;
    logic [7:0]  mon_recon;
    int          mon_sh = 0;

    int order[256];

    int_fp_norm #(.EXP_BASE(EXP_BASE)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_int      (in_int),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .sign_o      (sign_o),
        .exp_o       (exp_o),
        .frac_o      (frac_o),
        .dbg_state_o (dbg_state)
    );

    // Clock
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, want);
        end
    endtask

    // Reference: locate the leading one of the magnitude arithmetically.
    function automatic logic [W-1:0] model(input logic [7:0] v);
        int m, k, e, f, l;
        m = int'(v[6:0]);
        k = -1;
        for (int b = 0; b < 7; b++) begin
            if (m >= (1 << b)) k = b;
        end
        if (k < 0) begin
            e = 0;
            f = 0;
            l = 2;
        end else begin
            f = (m << (7 - k)) & 255;
            e = int'(EXP_BASE) - 6 + k;
            l = 2 + (6 - k);
        end
`ifdef FP_NORM_FAST_EN
        l = 2;
`endif
        return {v, 4'(e), 8'(f), 6'(l)};
    endfunction

    // Downstream ready: 0 = always ready, 1 = random, 2 = held low.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                0:       out_ready = 1'b1;
                1:       out_ready = ($urandom_range(0, 3) != 0);
                default: out_ready = 1'b0;
            endcase
        end
    end

    // Driver: present a word only when the block is idle, record expectation.
    task automatic send_word(input logic [7:0] v);
        int guard;
        guard = 0;
        @(negedge clk);
        while (!in_ready && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        if (!in_ready) begin
            n_cmp++;
            n_fail++;
            $display("FAIL send_timeout: got in_ready=0 expected in_ready=1 for word 0x%0h", v);
            return;
        end
        in_valid = 1'b1;
        in_int   = v;
        exp_q.push_back(model(v));
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_int   = 8'($urandom);
    endtask

    task automatic wait_idle();
        int guard;
        guard = 0;
        while ((exp_q.size() != 0 || out_valid) && guard < 500) begin
            @(negedge clk);
            guard++;
        end
        if (exp_q.size() != 0 || out_valid) begin
            n_cmp++;
            n_fail++;
            $display("FAIL idle_timeout: got %0d pending expected 0", exp_q.size());
        end
    endtask

    // Monitor: measure latency per word, pop and compare on each result handshake.
    initial begin
        forever begin
            @(posedge clk);
            if (rst_n && in_valid && in_ready) begin
                mon_tracking = 1'b1;
                mon_lat      = 1;
                mon_seen     = 1'b0;
            end else if (mon_tracking) begin
                mon_lat++;
            end
            @(negedge clk);
            if (!rst_n) begin
                mon_tracking  = 1'b0;
                mon_seen      = 1'b0;
                mon_have_snap = 1'b0;
            end else begin
                if (mon_tracking && !out_valid && mon_lat > 40) begin
                    n_cmp++;
                    n_fail++;
                    $display("FAIL latency_timeout: got no out_valid after %0d edges expected at most 8", mon_lat);
                    mon_tracking = 1'b0;
                end
                if (out_valid) begin
                    check("in_ready_in_done", 32'(in_ready), 32'd0);
                    if (!mon_seen) begin
                        mon_seen     = 1'b1;
                        mon_lat_seen = mon_lat;
                    end
                    if (mon_have_snap) begin
                        check("stall_stable", 32'({sign_o, exp_o, frac_o}), 32'(mon_snap));
                    end
                    if (out_ready) begin
                        if (exp_q.size() == 0) begin
                            n_cmp++;
                            n_fail++;
                            $display("FAIL unexpected_output: got 0x%0h expected no output",
                                     {sign_o, exp_o, frac_o});
                        end else begin
                            mon_item = exp_q.pop_front();
                            check("sign", 32'(sign_o), 32'(mon_item[25]));
                            check("exp", 32'(exp_o), 32'(mon_item[17:14]));
                            check("frac", 32'(frac_o), 32'(mon_item[13:6]));
                            check("latency", 32'(mon_lat_seen), 32'(mon_item[5:0]));
                            if (frac_o == 8'h00) begin
                                mon_recon = {sign_o, 7'h00};
                            end else begin
                                mon_sh = 11 - int'(exp_o);
                                if (mon_sh < 0) mon_sh = 0;
                                mon_recon = {sign_o, 7'(frac_o >> mon_sh)};
                            end
                            check("round_trip", 32'(mon_recon), 32'(mon_item[25:18]));
                        end
                        mon_tracking  = 1'b0;
                        mon_seen      = 1'b0;
                        mon_have_snap = 1'b0;
                    end else begin
                        mon_snap      = {sign_o, exp_o, frac_o};
                        mon_have_snap = 1'b1;
                    end
                end
            end
        end
    end

    // Main sequence
    initial begin
        logic [7:0] directed[8];
        int guard;
        int j, tmp;
        directed = '{8'h05, 8'hC0, 8'h7F, 8'h80, 8'h00, 8'h01, 8'h40, 8'hFF};

        // Reset state
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_fields", 32'({sign_o, exp_o, frac_o}), 32'd0);
        @(posedge clk);
        #2;
        rst_n = 1'b1;

        // Directed corner words, always-ready downstream
        ready_mode = 0;
        foreach (directed[i]) send_word(directed[i]);
        wait_idle();

        // Stall in DONE; a word offered meanwhile must be ignored
        ready_mode = 2;
        send_word(8'h05);
        guard = 0;
        while (!out_valid && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        check("stall_reached_done", 32'(out_valid), 32'd1);
        in_valid = 1'b1;
        in_int   = 8'h33;
        repeat (5) begin
            @(negedge clk);
            check("stall_in_ready", 32'(in_ready), 32'd0);
            check("stall_out_valid", 32'(out_valid), 32'd1);
        end
        in_valid   = 1'b0;
        ready_mode = 0;
        @(negedge clk);
        @(negedge clk);
        check("ready_after_handshake", 32'(in_ready), 32'd1);
        check("valid_after_handshake", 32'(out_valid), 32'd0);
        wait_idle();

        // Reset while normalising 0x01
        send_word(8'h01);
        repeat (3) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("abort_out_valid", 32'(out_valid), 32'd0);
        check("abort_fields", 32'({sign_o, exp_o, frac_o}), 32'd0);
        check("abort_in_ready", 32'(in_ready), 32'd1);
        exp_q.delete();
        @(negedge clk);
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        send_word(8'h01);
        wait_idle();

        // Shuffled sweep of every input value with random backpressure
        for (int i = 0; i < 256; i++) order[i] = i;
        for (int i = 255; i > 0; i--) begin
            j = $urandom_range(0, i);
            tmp = order[i];
            order[i] = order[j];
            order[j] = tmp;
        end
        ready_mode = 1;
        for (int i = 0; i < 256; i++) begin
            repeat ($urandom_range(0, 2)) @(negedge clk);
            send_word(8'(order[i]));
        end
        ready_mode = 0;
        wait_idle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    // Watchdog
    initial begin
        #2000000;
        n_cmp++;
        n_fail++;
        $display("FAIL watchdog: got run still active expected completion");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
